// File: rtl/tx_shaper_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : tx_shaper_pkg
//  Description : Shared constants, types, the raised-cosine coefficient ROM
//                (rolloff 0.5, 4x oversampled, 6-symbol span) and the
//                bit-to-sign helper for the TX pulse-shaping filter.
//  Revision    : 1.0 - initial release
// ============================================================================
package tx_shaper_pkg;

    localparam int OS     = 4;                  // samples per symbol
    localparam int NBAUDS = 6;                  // filter span in symbols
    localparam int COEF_W = 8;                  // S(8,7)
    localparam int OUT_W  = 11;                 // S(11,7)
    localparam int TAPS   = OS * NBAUDS;
    localparam int TAP_W  = $clog2(TAPS);
    localparam int PH_W   = $clog2(OS);

    typedef logic signed [COEF_W-1:0] coef_t;
    typedef logic signed [OUT_W-1:0]  sample_t;

    // h[k] = round(127 * rc((k-12)/4)); zeros land on the symbol-spaced
    // Nyquist crossings, and the table is symmetric about the centre tap.
    localparam coef_t COEF [TAPS] = '{
        8'sd0,    8'sd1,    8'sd2,    8'sd3,
        8'sd0,   -8'sd7,   -8'sd15,  -8'sd16,
        8'sd0,    8'sd33,   8'sd76,   8'sd113,
        8'sd127,  8'sd113,  8'sd76,   8'sd33,
        8'sd0,   -8'sd16,  -8'sd15,  -8'sd7,
        8'sd0,    8'sd3,    8'sd2,    8'sd1
    };

    // Maps a PRBS bit onto a signed tap contribution: bit 0 -> +h, bit 1 -> -h.
    function automatic sample_t bit_to_sign(input logic b, input coef_t h);
        sample_t ext;
        ext = sample_t'(h);
        return b ? -ext : ext;
    endfunction

endpackage : tx_shaper_pkg
`default_nettype wire

// File: rtl/tx_rc_branch.sv
`default_nettype none
// ============================================================================
//  Module      : tx_rc_branch
//  Description : One branch (I or Q) of the polyphase shaper: the symbol
//                shift register plus the polyphase sum for the current phase.
//  Ports       : clock, reset   - clock / async active-high reset
//                enable         - clock enable, state holds when low
//                shift          - accept new_bit into the shift register
//                new_bit        - incoming PRBS bit
//                phase          - polyphase index used this cycle
//                occ            - updated occupancy mask (this cycle's view)
//                sample         - registered shaped output sample
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_rc_branch
    import tx_shaper_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    input  logic              shift,
    input  logic              new_bit,
    input  logic [PH_W-1:0]   phase,
    input  logic [NBAUDS-1:0] occ,
    output sample_t           sample
);

    logic [NBAUDS-1:0] sym;
    logic [NBAUDS-1:0] sym_next;
    logic [TAP_W-1:0]  tap_idx;
    sample_t           acc;

    // The sum uses the post-shift window so a new symbol is already at j = 0.
    assign sym_next = shift ? {sym[NBAUDS-2:0], new_bit} : sym;

    always_comb begin
        acc     = '0;
        tap_idx = '0;
        for (int j = 0; j < NBAUDS; j++) begin
            tap_idx = TAP_W'(OS * j) + TAP_W'(phase);
            if (occ[j]) begin
                acc = acc + bit_to_sign(sym_next[j], COEF[tap_idx]);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sym    <= '0;
            sample <= '0;
        end else if (enable) begin
            sym    <= sym_next;
            sample <= acc;
        end
    end

endmodule : tx_rc_branch
`default_nettype wire

// File: rtl/tx_rc_shaper.sv
`default_nettype none
// ============================================================================
//  Module      : tx_rc_shaper
//  Description : Polyphase raised-cosine pulse shaper for the TX I/Q chain.
//                One bit per branch per symbol strobe in, OS shaped signed
//                samples per symbol out. Phase counter, occupancy mask and
//                coefficient ROM are shared by both branches.
//  Ports       : clock, i_reset     - clock / async active-high reset
//                i_enable           - clock enable, all state holds when low
//                i_valid            - symbol strobe
//                i_bit_I, i_bit_Q   - PRBS bits per branch
//                o_I, o_Q           - shaped samples, signed S(11,7)
//                o_valid            - new sample present this cycle
//                o_phase            - polyphase index of the current sample
//  Revision    : 1.0 - initial release
// ============================================================================
module tx_rc_shaper
    import tx_shaper_pkg::*;
(
    input  logic                    clock,
    input  logic                    i_reset,
    input  logic                    i_enable,
    input  logic                    i_valid,
    input  logic                    i_bit_I,
    input  logic                    i_bit_Q,
    output logic signed [OUT_W-1:0] o_I,
    output logic signed [OUT_W-1:0] o_Q,
    output logic                    o_valid,
    output logic [PH_W-1:0]         o_phase
);

    logic              accept;
    logic [PH_W-1:0]   phase;
    logic [PH_W-1:0]   phase_inc;
    logic [PH_W-1:0]   phase_eff;
    logic [NBAUDS-1:0] occ;
    logic [NBAUDS-1:0] occ_next;

    assign accept    = i_enable & i_valid;
    // Free-running wrap when strobes are late; a strobe always resyncs to 0.
    assign phase_inc = (phase == PH_W'(OS - 1)) ? '0 : phase + PH_W'(1);
    assign phase_eff = i_valid ? '0 : phase_inc;
    // Shifting a 1 in from the bottom saturates the mask after NBAUDS symbols.
    assign occ_next  = accept ? {occ[NBAUDS-2:0], 1'b1} : occ;

    // The phase register is the phase of the sample currently on o_I/o_Q.
    always_ff @(posedge clock or posedge i_reset) begin
        if (i_reset) begin
            phase   <= '0;
            occ     <= '0;
            o_valid <= 1'b0;
        end else if (i_enable) begin
            phase   <= phase_eff;
            occ     <= occ_next;
            o_valid <= occ_next[0];
        end else begin
            o_valid <= 1'b0;
        end
    end

    assign o_phase = phase;

    tx_rc_branch u_branch_i (
        .clock   (clock),
        .reset   (i_reset),
        .enable  (i_enable),
        .shift   (accept),
        .new_bit (i_bit_I),
        .phase   (phase_eff),
        .occ     (occ_next),
        .sample  (o_I)
    );

    tx_rc_branch u_branch_q (
        .clock   (clock),
        .reset   (i_reset),
        .enable  (i_enable),
        .shift   (accept),
        .new_bit (i_bit_Q),
        .phase   (phase_eff),
        .occ     (occ_next),
        .sample  (o_Q)
    );

endmodule : tx_rc_shaper
`default_nettype wire
